// File: rtl/dlx_pkg.sv
// Shared DLX definitions used by the fetch and decode stages:
// the NOP encoding, primary opcodes and the fetch-stage state type.
package dlx_pkg;

    localparam logic [31:0] DLX_NOP = 32'h0000_0015;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    // DLX numbers bit 0 as the MSB, so opcode [0:5] is vector bits [31:26].
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus: one outstanding request at a time,
// response marked by imem_rvalid at least one cycle after imem_req.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_buffer.sv
// One-entry skid register holding an instruction word and its PC+4 while
// decode is stalled; clear and unload both empty it, clear takes priority.
module fetch_buffer
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc4_i,
    output logic        full_o,
    output logic [31:0] data_o,
    output logic [31:0] pc4_o
);

    logic        full_q, full_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc4_q, pc4_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pc4_d  = pc4_q;
        if (clear_i || unload_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            pc4_d  = pc4_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= DLX_NOP;
            pc4_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pc4_q  <= pc4_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign pc4_o  = pc4_q;

endmodule

// File: rtl/instruction_fetch.sv
// DLX instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry response skid buffer and the IF/ID register feeding decode.
module instruction_fetch
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DLX_NOP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_if.master        imem,
    input  logic                       branch_taken,
    input  logic [31:0]                new_pc,
    input  logic                       stall,
    input  logic                       kill_next_instruction,
    output logic [31:0]                instr,
    output logic [31:0]                pc_plus_four,
    output logic                       instr_valid,
    output logic                       should_be_killed
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ppf_q, ppf_d;
    logic         valid_q, valid_d;
    logic         kill_q, kill_d;

    logic         buf_load, buf_unload, buf_clear, buf_full;
    logic [31:0]  buf_data, buf_pc4;
    logic [31:0]  pc_inc;

    assign pc_inc = pc_q + 32'd4;

    fetch_buffer u_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .clear_i  (buf_clear),
        .data_i   (imem.imem_rdata),
        .pc4_i    (pc_inc),
        .full_o   (buf_full),
        .data_o   (buf_data),
        .pc4_o    (buf_pc4)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        ppf_d          = ppf_q;
        valid_d        = valid_q;
        kill_d         = stall ? kill_q : kill_next_instruction;
        buf_load       = 1'b0;
        buf_unload     = 1'b0;
        buf_clear      = 1'b0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;

        if (branch_taken) begin
            // No request goes out in a redirect cycle; FLUSH swallows a response still in flight.
            pc_d      = {new_pc[31:2], 2'b00};
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            buf_clear = 1'b1;
            kill_d    = kill_next_instruction;
            state_d   = ((state_q == WAIT || state_q == FLUSH) && !imem.imem_rvalid) ? FLUSH : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!buf_full) begin
                        // Reset state is FETCH, so keep the request low while rst_n is asserted.
                        imem.imem_req = rst_n;
                        state_d       = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!stall) begin
                            instr_d = imem.imem_rdata;
                            ppf_d   = pc_inc;
                            valid_d = 1'b1;
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d    = buf_data;
                        ppf_d      = buf_pc4;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                        buf_unload = 1'b1;
                        state_d    = FETCH;
                    end
                end
                FLUSH: begin
                    if (imem.imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ppf_q   <= RESET_PC;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ppf_q   <= ppf_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
        end
    end

    assign instr            = instr_q;
    assign pc_plus_four     = ppf_q;
    assign instr_valid      = valid_q;
    assign should_be_killed = kill_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// redirect/stall/kill traffic against a transaction-level fetch model.
module tb_instruction_fetch;
    import dlx_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] new_pc;
    logic        stall;
    logic        kill_next_instruction;
    logic [31:0] instr;
    logic [31:0] pc_plus_four;
    logic        instr_valid;
    logic        should_be_killed;

    instruction_fetch_if imem ();

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (DLX_NOP)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .imem                  (imem),
        .branch_taken          (branch_taken),
        .new_pc                (new_pc),
        .stall                 (stall),
        .kill_next_instruction (kill_next_instruction),
        .instr                 (instr),
        .pc_plus_four          (pc_plus_four),
        .instr_valid           (instr_valid),
        .should_be_killed      (should_be_killed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int mem_lat;

    // Memory: each accepted request answers mem_lat cycles later (random 1..3 when mem_lat is 0).
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    // Reference model: fetch pipeline described by flags, not by the DUT's state type.
    logic [31:0] m_pc, m_instr, m_ppf, m_skid_word, m_skid_ppf;
    logic        m_valid, m_kill, m_out, m_drop, m_skid;

    logic        obs_req, exp_req;
    logic [31:0] obs_addr, exp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = DLX_NOP; m_ppf = RESET_PC; m_valid = 1'b0; m_kill = 1'b0;
        m_out = 1'b0; m_drop = 1'b0; m_skid = 1'b0; m_skid_word = '0; m_skid_ppf = '0;
    endtask

    task automatic model_step(input logic br, input logic [31:0] np, input logic st,
                              input logic kl, input logic rv, input logic [31:0] rd);
        logic req;
        req = !m_out && !m_skid && !br;
        if (br) begin
            m_pc = np & 32'hFFFF_FFFC; m_instr = DLX_NOP; m_valid = 1'b0; m_skid = 1'b0; m_kill = kl;
            m_drop = m_out && !rv;
            m_out  = m_drop;
        end else begin
            if (!st) m_kill = kl;
            if (req) begin
                m_out = 1'b1; m_drop = 1'b0;
            end else if (m_out && rv) begin
                m_out = 1'b0;
                if (m_drop) m_drop = 1'b0;
                else if (!st) begin
                    m_instr = rd; m_ppf = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
                end else begin
                    m_skid = 1'b1; m_skid_word = rd; m_skid_ppf = m_pc + 32'd4;
                end
            end else if (m_skid && !st) begin
                m_instr = m_skid_word; m_ppf = m_skid_ppf; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_skid = 1'b0;
            end
        end
    endtask

    // One clock: inputs at negedge, request sampled #1 later, memory/model advance on posedge.
    task automatic drive_cycle(input logic br, input logic [31:0] np, input logic st, input logic kl);
        logic        rv;
        logic [31:0] rd;
        int          lat;
        @(negedge clk);
        rst_n = 1'b1;
        branch_taken = br; new_pc = np; stall = st; kill_next_instruction = kl;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        rd = rv ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rd;
        exp_req  = !m_out && !m_skid && !br;
        exp_addr = m_pc;
        #1;
        obs_req  = imem.imem_req;
        obs_addr = imem.imem_addr;
        @(posedge clk);
        if (rv) void'(mq.pop_front());
        if (obs_req) begin
            lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 3));
            mq.push_back('{addr: obs_addr, due: cyc + lat});
        end
        cyc++;
        model_step(br, np, st, kl, rv, rd);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem.imem_req); end
        checks++; if (instr !== DLX_NOP) begin fails++; $display("FAIL reset_instr got %h want %h", instr, DLX_NOP); end
        checks++; if (pc_plus_four !== RESET_PC) begin fails++; $display("FAIL reset_ppf got %h want %h", pc_plus_four, RESET_PC); end
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (should_be_killed !== 1'b0) begin fails++; $display("FAIL reset_kill got %b want 0", should_be_killed); end
        $display("reset: instr=%h ppf=%h valid=%b", instr, pc_plus_four, instr_valid);
    endtask

    task automatic test_first_fetch();
        mem_lat = 1;
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin fails++; $display("FAIL first_req got req=%b addr=%h want 1 %h", obs_req, obs_addr, RESET_PC); end
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL first_early_valid got %b want 0", instr_valid); end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instr !== 32'h2001_0005) begin fails++; $display("FAIL first_instr got %h want 20010005", instr); end
        checks++; if (pc_plus_four !== 32'd4) begin fails++; $display("FAIL first_ppf got %h want 4", pc_plus_four); end
        checks++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b want 1", instr_valid); end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'd4) begin fails++; $display("FAIL second_req got req=%b addr=%h want 1 4", obs_req, obs_addr); end
        $display("first_fetch: instr=%h ppf=%h next_addr=%h", instr, pc_plus_four, obs_addr);
    endtask

    task automatic test_stall();
        logic [31:0] a, s_instr, s_ppf;
        logic        found = 1'b0;
        mem_lat = 1;
        for (int i = 0; i < 8 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            found = obs_req;
        end
        checks++; if (!found) begin fails++; $display("FAIL stall_setup got no request want request"); end
        a = obs_addr; s_instr = instr; s_ppf = pc_plus_four;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            checks++; if (instr !== s_instr || pc_plus_four !== s_ppf) begin fails++; $display("FAIL stall_hold got %h/%h want %h/%h", instr, pc_plus_four, s_instr, s_ppf); end
            checks++; if (obs_req !== 1'b0) begin fails++; $display("FAIL stall_req got %b want 0", obs_req); end
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instr !== mem_word(a)) begin fails++; $display("FAIL stall_release_instr got %h want %h", instr, mem_word(a)); end
        checks++; if (pc_plus_four !== s_ppf + 32'd4 || pc_plus_four !== a + 32'd4) begin fails++; $display("FAIL stall_release_ppf got %h want %h", pc_plus_four, a + 32'd4); end
        $display("stall: addr=%h instr=%h ppf=%h", a, instr, pc_plus_four);
    endtask

    task automatic test_redirect_outstanding();
        logic found = 1'b0;
        mem_lat = 3;
        for (int i = 0; i < 8 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            found = obs_req;
        end
        drive_cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        checks++; if (instr !== DLX_NOP || instr_valid !== 1'b0) begin fails++; $display("FAIL redir_out_bubble got %h/%b want %h/0", instr, instr_valid, DLX_NOP); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            if (obs_req) found = 1'b1;
            else begin
                checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_out_stale got valid=%b instr=%h want 0", instr_valid, instr); end
            end
        end
        checks++; if (!found || obs_addr !== 32'h100) begin fails++; $display("FAIL redir_out_addr got req=%b addr=%h want 1 00000100", found, obs_addr); end
        $display("redirect_outstanding: next_addr=%h", obs_addr);
    endtask

    task automatic test_redirect_rvalid();
        logic found = 1'b0;
        mem_lat = 1;
        for (int i = 0; i < 8 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            found = obs_req;
        end
        drive_cycle(1'b1, 32'h0000_0203, 1'b0, 1'b0);
        checks++; if (instr !== DLX_NOP || instr_valid !== 1'b0) begin fails++; $display("FAIL redir_rv_discard got %h/%b want %h/0", instr, instr_valid, DLX_NOP); end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin fails++; $display("FAIL redir_rv_addr got req=%b addr=%h want 1 00000200", obs_req, obs_addr); end
        $display("redirect_rvalid: next_addr=%h", obs_addr);
    endtask

    task automatic test_kill_stall();
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        checks++; if (should_be_killed !== 1'b1) begin fails++; $display("FAIL kill_set got %b want 1", should_be_killed); end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            checks++; if (should_be_killed !== 1'b1) begin fails++; $display("FAIL kill_hold got %b want 1", should_be_killed); end
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (should_be_killed !== 1'b0) begin fails++; $display("FAIL kill_follow got %b want 0", should_be_killed); end
        $display("kill_stall: should_be_killed=%b", should_be_killed);
    endtask

    task automatic test_wrap();
        logic found = 1'b0;
        mem_lat = 1;
        drive_cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        for (int i = 0; i < 8 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            found = obs_req;
        end
        checks++; if (!found || obs_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got req=%b addr=%h want 1 fffffffc", found, obs_addr); end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (pc_plus_four !== 32'h0 || instr !== mem_word(32'hFFFF_FFFC) || instr_valid !== 1'b1) begin fails++; $display("FAIL wrap_ppf got %h/%h/%b want 0/%h/1", pc_plus_four, instr, instr_valid, mem_word(32'hFFFF_FFFC)); end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin fails++; $display("FAIL wrap_next got req=%b addr=%h want 1 0", obs_req, obs_addr); end
        $display("wrap: ppf=%h next_addr=%h", pc_plus_four, obs_addr);
    endtask

    task automatic test_reset_mid_fetch();
        logic found = 1'b0;
        mem_lat = 2;
        drive_cycle(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        for (int i = 0; i < 8 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            found = obs_req;
        end
        @(negedge clk);
        rst_n = 1'b0; branch_taken = 1'b0; stall = 1'b0; kill_next_instruction = 1'b0;
        imem.imem_rvalid = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b0 || instr !== DLX_NOP || pc_plus_four !== RESET_PC || instr_valid !== 1'b0 || should_be_killed !== 1'b0) begin
            fails++; $display("FAIL midreset_values got req=%b instr=%h ppf=%h valid=%b kill=%b want 0 %h %h 0 0", imem.imem_req, instr, pc_plus_four, instr_valid, should_be_killed, DLX_NOP, RESET_PC);
        end
        @(posedge clk);
        cyc++;
        model_reset();
        #1;
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin fails++; $display("FAIL midreset_first_req got req=%b addr=%h want 1 %h", obs_req, obs_addr, RESET_PC); end
        checks++; if (instr_valid !== 1'b0 || instr !== DLX_NOP) begin fails++; $display("FAIL midreset_late_resp got %h/%b want %h/0", instr, instr_valid, DLX_NOP); end
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            found = instr_valid;
        end
        checks++; if (!found || instr !== 32'h2001_0005 || pc_plus_four !== 32'd4) begin fails++; $display("FAIL midreset_refetch got %b/%h/%h want 1/20010005/4", found, instr, pc_plus_four); end
        $display("reset_mid_fetch: instr=%h ppf=%h", instr, pc_plus_four);
    endtask

    task automatic test_random();
        logic        br, st, kl;
        logic [31:0] np;
        int          start_fails = fails;
        mem_lat = 0;
        for (int i = 0; i < 600; i++) begin
            br = ($urandom_range(0, 11) == 0);
            np = $urandom;
            st = ($urandom_range(0, 3) == 0);
            kl = 1'($urandom_range(0, 1));
            drive_cycle(br, np, st, kl);
            checks++; if (obs_req !== exp_req) begin fails++; $display("FAIL rand_req cyc=%0d got %b want %b", cyc, obs_req, exp_req); end
            if (exp_req) begin
                checks++; if (obs_addr !== exp_addr) begin fails++; $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, obs_addr, exp_addr); end
            end
            checks++; if (instr !== m_instr) begin fails++; $display("FAIL rand_instr cyc=%0d got %h want %h", cyc, instr, m_instr); end
            checks++; if (pc_plus_four !== m_ppf) begin fails++; $display("FAIL rand_ppf cyc=%0d got %h want %h", cyc, pc_plus_four, m_ppf); end
            checks++; if (instr_valid !== m_valid) begin fails++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, instr_valid, m_valid); end
            checks++; if (should_be_killed !== m_kill) begin fails++; $display("FAIL rand_kill cyc=%0d got %b want %b", cyc, should_be_killed, m_kill); end
        end
        $display("random: 600 cycles, %0d new failures", fails - start_fails);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        branch_taken = 1'b0; new_pc = '0; stall = 1'b0; kill_next_instruction = 1'b0;
        imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        mem_lat = 1;
        model_reset();
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_outstanding();
        test_redirect_rvalid();
        test_kill_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
